// File: rtl/cpu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cpu_sequencer
// Brief   : Multi-cycle FETCH/DECODE/EXEC/WB control unit with 16x16 regfile
//           driving an external combinational ALU.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int PC_W     = 8,
    parameter int ALU_WAIT = 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    input  logic [15:0]     alu_out,
    output logic [PC_W-1:0] pc,
    output logic            retire,
    output logic            halted,
    input  logic [3:0]      rf_dbg_addr,
    output logic [15:0]     rf_dbg_data
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_LDI  = 4'b0010;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    // Control vectors ordered {zx, nx, zy, ny, f, no}
    localparam logic [5:0] c_CTRL_ADD = 6'b000010;
    localparam logic [5:0] c_CTRL_SUB = 6'b010011;

    localparam int c_WAIT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(ALU_WAIT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PC_W-1:0]       r_pc;
    logic [15:0]           r_ir;
    logic [15:0]           r_rf [16];
    logic                  r_req;
    logic                  r_retire;
    logic                  r_halted;
    logic [15:0]           r_alu_x;
    logic [15:0]           r_alu_y;
    logic [5:0]            r_ctrl;
    logic [c_WAIT_W-1:0]   r_wait;

    logic [3:0]            w_op;
    logic [3:0]            w_rd;
    logic [3:0]            w_rs1;
    logic [3:0]            w_rs2;
    logic [7:0]            w_imm;
    logic                  w_is_alu;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:8];
    assign w_rs1    = r_ir[7:4];
    assign w_rs2    = r_ir[3:0];
    assign w_imm    = r_ir[7:0];
    assign w_is_alu = (w_op == c_OP_ADD) || (w_op == c_OP_SUB);

    always_comb begin
        w_next = r_state;
        case (r_state)
            // Ack is only honoured once the request is actually on the bus
            S_FETCH:  if (r_req && imem_ack) w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_alu)               w_next = S_EXEC;
                else if (w_op == c_OP_HALT) w_next = S_HALT;
                else                        w_next = S_WB;
            end
            S_EXEC:   if (r_wait == '0) w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_req    <= 1'b0;
            r_retire <= 1'b0;
            r_halted <= 1'b0;
            r_alu_x  <= '0;
            r_alu_y  <= '0;
            r_ctrl   <= '0;
            r_wait   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_state  <= w_next;
            r_req    <= (w_next == S_FETCH);
            r_retire <= (w_next == S_WB);
            if (w_next == S_HALT) r_halted <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (w_next == S_DECODE) r_ir <= imem_data;
                end
                S_DECODE: begin
                    // Operands sampled here, so rd aliasing a source reads the old value
                    if (w_is_alu) begin
                        r_alu_x <= r_rf[w_rs1];
                        r_alu_y <= r_rf[w_rs2];
                        r_ctrl  <= (w_op == c_OP_SUB) ? c_CTRL_SUB : c_CTRL_ADD;
                        r_wait  <= c_WAIT_LOAD;
                    end
                end
                S_EXEC: begin
                    if (r_wait != '0) r_wait <= r_wait - 1'b1;
                end
                S_WB: begin
                    if (w_is_alu)              r_rf[w_rd] <= alu_out;
                    else if (w_op == c_OP_LDI) r_rf[w_rd] <= {8'h00, w_imm};
                    r_pc   <= r_pc + 1'b1;
                    r_ctrl <= '0;
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign retire      = r_retire;
    assign halted      = r_halted;
    assign alu_x       = r_alu_x;
    assign alu_y       = r_alu_y;
    assign alu_zx      = r_ctrl[5];
    assign alu_nx      = r_ctrl[4];
    assign alu_zy      = r_ctrl[3];
    assign alu_ny      = r_ctrl[2];
    assign alu_f       = r_ctrl[1];
    assign alu_no      = r_ctrl[0];
    assign rf_dbg_data = r_rf[rf_dbg_addr];

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control unit for the 16-bit CPU datapath. It fetches instructions from program memory over a req/ack handshake, decodes them, and holds the 16x16 register file. It drives the external ALU's operands and six control bits, writes results back, and advances the PC. It replaces ad-hoc per-clock decode with an explicit FSM, so that ALU settle time and memory wait states are honoured.

Parameters:
PC_W, 8, program counter / instruction address width (word addressed)
ALU_WAIT, 1, cycles spent in EXEC waiting for the combinational ALU to settle (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  16  instruction word
alu_x  out  16  ALU operand x
alu_y  out  16  ALU operand y
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
alu_out  in  16  ALU result
pc  out  PC_W  current program counter
retire  out  1  one-cycle pulse per completed non-halt instruction
halted  out  1  high once HALT executes
rf_dbg_addr  in  4  debug register-file read address
rf_dbg_data  out  16  R[rf_dbg_addr], combinational

Behaviour:
- Reset (async, immediate): state=FETCH, pc=0, IR=0, all 16 registers=0, imem_req=0, alu_x=alu_y=0, all ALU control bits=0, retire=0, halted=0.
- Instruction format: IR[15:12] opcode, IR[11:8] rd, IR[7:4] rs1, IR[3:0] rs2 / IR[7:0] imm8.
- Opcodes:
  - 0000 ADD: R[rd]=R[rs1]+R[rs2]; ctrl zx=0 nx=0 zy=0 ny=0 f=1 no=0.
  - 0001 SUB: R[rd]=R[rs1]-R[rs2]; ctrl nx=1 f=1 no=1, others 0.
  - 0010 LDI: R[rd]={8'h00,imm8}; ALU unused.
  - 1111 HALT.
  - Any other opcode is a NOP: no write, pc+1, retire pulses.
- States:
  - FETCH: imem_req=1 (registered), imem_addr=pc held stable. On a posedge with imem_ack=1, latch IR=imem_data, drop req, go to DECODE. Otherwise stay. imem_ack while not in FETCH is ignored.
  - DECODE: for ADD/SUB, register alu_x=R[rs1], alu_y=R[rs2] and the control bits, then go to EXEC. LDI and NOP go to WB. HALT goes to HALT.
  - EXEC: stay ALU_WAIT cycles, then go to WB. Operands and control stay stable throughout EXEC.
  - WB: write back (alu_out for ADD/SUB, imm8 for LDI), pc=pc+1 modulo 2^PC_W (wraps to 0), retire=1 for exactly this cycle, then go to FETCH. ALU control bits return to 0.
  - HALT: halted=1, imem_req=0, pc frozen, no writes. Left only by reset.
- Operand reads happen in DECODE, so rd equal to rs1 or rs2 reads the old value.
- Latency with zero-wait memory (ack in the first FETCH cycle) and ALU_WAIT=1:
  - ADD/SUB: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDI/NOP: 3 cycles.
  - Each memory wait cycle adds 1.
- Reset mid-instruction abandons it: no partial write, pc=0, fetch restarts at address 0 on the first clock after deassertion.

Test Plan:
- Zero-wait program {2105, 2203, 0312, F000} -> R1=5, R2=3, R3=8; 3 retire pulses; halted=1; pc frozen at 3; imem_req=0 thereafter.
- After R1=5, R2=3, run SUB 1412 then SUB 1521 -> R4=0x0002, R5=0xFFFE. During EXEC, ctrl nx=1 f=1 no=1 zx=zy=ny=0, and alu_x/alu_y equal the source registers.
- Ack delayed 3 cycles on an ADD fetch -> imem_req and imem_addr stable for 4 cycles; IR latched only on the ack edge; instruction takes 7 cycles total.
- Reset pulsed mid-EXEC of ADD -> outputs reach reset values without a clock edge; R[rd] unchanged (0); the first fetch after release is from address 0.
- Opcode 0x5123 -> no register changes; pc+1; one retire pulse; 3-cycle latency.
- PC_W=4, 16 LDI instructions and no HALT -> pc goes 15 -> 0 and execution continues from address 0; ALU_WAIT=3 run of an ADD -> EXEC lasts exactly 3 cycles.
